// File: rtl/memory_unit_banked_if.sv
// Bus interface for memory_unit_banked: DMEM read/write ports, instruction
// fetch/write port, control register and the ready/clear handshake.
// Optional build macro: MEM_PARITY_EN adds oParityError and iParityInject.
//
// Handshake: oReady is a level, not a pulse. While oReady=0 the unit is
// clearing DMEM; DMEM writes presented then are dropped and DMEM read data
// is forced to 0. Once oReady=1 every access is accepted on the clock edge
// it is presented on, with no back-pressure, until the next Reset.
interface memory_unit_banked_if #(
  parameter int LANES           = 3,
  parameter int LANE_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 7,
  parameter int INST_WIDTH      = 64,
  parameter int INST_ADDR_WIDTH = 16,
  parameter int CR_WIDTH        = 16
);
  localparam int DATA_WIDTH = LANES * LANE_WIDTH;

  logic                       oReady;
  logic                       oDbgState;
  logic                       iDataWriteEnable;
  logic [LANES-1:0]           iDataWriteLaneMask;
  logic [DATA_ADDR_WIDTH-1:0] iDataWriteAddress;
  logic [DATA_WIDTH-1:0]      iData;
  logic [DATA_ADDR_WIDTH-1:0] iDataReadAddress1;
  logic [DATA_ADDR_WIDTH-1:0] iDataReadAddress2;
  logic [DATA_WIDTH-1:0]      oData1;
  logic [DATA_WIDTH-1:0]      oData2;
  logic                       iInstructionWriteEnable;
  logic [INST_ADDR_WIDTH-1:0] iInstructionWriteAddress;
  logic [INST_WIDTH-1:0]      iInstruction;
  logic [INST_ADDR_WIDTH-1:0] iInstructionReadAddress;
  logic [INST_WIDTH-1:0]      oInstruction;
  logic                       iControlWriteEnable;
  logic [CR_WIDTH-1:0]        iControlRegister;
  logic [CR_WIDTH-1:0]        oControlRegister;
`ifdef MEM_PARITY_EN
  logic [2*LANES-1:0]         oParityError;
  logic                       iParityInject;
`endif

  // Requester side: drives strobes, addresses and write data.
  modport master (
    input  oReady, oDbgState, oData1, oData2, oInstruction, oControlRegister,
`ifdef MEM_PARITY_EN
    input  oParityError,
    output iParityInject,
`endif
    output iDataWriteEnable, iDataWriteLaneMask, iDataWriteAddress, iData,
    output iDataReadAddress1, iDataReadAddress2,
    output iInstructionWriteEnable, iInstructionWriteAddress, iInstruction,
    output iInstructionReadAddress, iControlWriteEnable, iControlRegister
  );

  // Memory side: the memory unit itself.
  modport slave (
    output oReady, oDbgState, oData1, oData2, oInstruction, oControlRegister,
`ifdef MEM_PARITY_EN
    output oParityError,
    input  iParityInject,
`endif
    input  iDataWriteEnable, iDataWriteLaneMask, iDataWriteAddress, iData,
    input  iDataReadAddress1, iDataReadAddress2,
    input  iInstructionWriteEnable, iInstructionWriteAddress, iInstruction,
    input  iInstructionReadAddress, iControlWriteEnable, iControlRegister
  );
endinterface

// File: rtl/memory_unit_banked.sv
// Banked memory unit: lane-masked DMEM with two registered read ports and
// write-to-read bypass, post-reset hardware clear of DMEM, writable IMEM
// muxed with a fixed instruction ROM, and a loadable control register.
// Optional build macro: MEM_PARITY_EN (per-lane even parity on DMEM).
// IROM contents: word at index k is {32'hC0DE0000 | k, 32'h5A5A0000 | k}.
module memory_unit_banked #(
  parameter int LANES           = 3,
  parameter int LANE_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 7,
  parameter int INST_WIDTH      = 64,
  parameter int INST_ADDR_WIDTH = 16,
  parameter int IMEM_ADDR_WIDTH = 10,
  parameter int CR_WIDTH        = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  memory_unit_banked_if.slave bus
);
  localparam int DATA_WIDTH = LANES * LANE_WIDTH;
  localparam int DEPTH      = 1 << DATA_ADDR_WIDTH;
  localparam int IMEM_DEPTH = 1 << IMEM_ADDR_WIDTH;

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t                     state_q;
  logic [DATA_ADDR_WIDTH-1:0] clr_cnt_q;
  logic                       ready_q;
  logic [DATA_WIDTH-1:0]      dmem [DEPTH];
  logic [DATA_WIDTH-1:0]      rd1_q, rd2_q;
  logic [DATA_WIDTH-1:0]      wr_row_d;
  logic                       wr_act;
  logic                       byp1, byp2;

  logic [INST_WIDTH-1:0]      imem [IMEM_DEPTH];
  logic [INST_WIDTH-1:0]      imem_rd_q, rom_rd_q;
  logic                       sel_imem_q;
  logic                       imem_wr;
  logic [IMEM_ADDR_WIDTH-1:0] imem_widx, imem_ridx;
  logic [CR_WIDTH-1:0]        cr_q;
  logic                       unused_addr_bits;

  // Fixed instruction ROM pattern, indexed by the wrapped fetch address.
  function automatic logic [INST_WIDTH-1:0] irom_word(input logic [IMEM_ADDR_WIDTH-1:0] idx);
    logic [63:0] w;
    w = {32'hC0DE_0000 | 32'(idx), 32'h5A5A_0000 | 32'(idx)};
    return INST_WIDTH'(w);
  endfunction

  // External DMEM writes only take effect once the clear has finished.
  assign wr_act = (state_q == ST_READY) && bus.iDataWriteEnable;
  assign byp1   = wr_act && (bus.iDataReadAddress1 == bus.iDataWriteAddress);
  assign byp2   = wr_act && (bus.iDataReadAddress2 == bus.iDataWriteAddress);

  // Merge write data into the current row: masked lanes new, others old.
  always_comb begin
    wr_row_d = dmem[bus.iDataWriteAddress];
    for (int l = 0; l < LANES; l++) begin
      if (bus.iDataWriteLaneMask[l]) wr_row_d[l*LANE_WIDTH +: LANE_WIDTH] = bus.iData[l*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  // Clear FSM: walk every DMEM row after reset, then raise oReady for good.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (&clr_cnt_q) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_READY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // DMEM storage: clear rows during CLEAR, merged-row writes afterwards.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      if (state_q == ST_CLEAR) dmem[clr_cnt_q] <= '0;
      else if (wr_act)         dmem[bus.iDataWriteAddress] <= wr_row_d;
    end
  end

  // Registered read ports; same-cycle write to the read row is forwarded.
  always_ff @(posedge Clock) begin
    if (Reset || state_q == ST_CLEAR) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= byp1 ? wr_row_d : dmem[bus.iDataReadAddress1];
      rd2_q <= byp2 ? wr_row_d : dmem[bus.iDataReadAddress2];
    end
  end

`ifdef MEM_PARITY_EN
  logic [LANES-1:0]   dpar [DEPTH];
  logic [LANES-1:0]   wr_par_d;
  logic [2*LANES-1:0] perr_q;

  // Merge new even-parity bits for masked lanes; inject flips them.
  always_comb begin
    wr_par_d = dpar[bus.iDataWriteAddress];
    for (int l = 0; l < LANES; l++) begin
      if (bus.iDataWriteLaneMask[l])
        wr_par_d[l] = (^bus.iData[l*LANE_WIDTH +: LANE_WIDTH]) ^ bus.iParityInject;
    end
  end

  // Parity storage tracks the DMEM row writes, including the clear.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      if (state_q == ST_CLEAR) dpar[clr_cnt_q] <= '0;
      else if (wr_act)         dpar[bus.iDataWriteAddress] <= wr_par_d;
    end
  end

  // Per-lane parity check on stored reads; forwarded rows never flag.
  always_ff @(posedge Clock) begin
    if (Reset || state_q == ST_CLEAR) begin
      perr_q <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        perr_q[l]       <= !byp1 && ((^dmem[bus.iDataReadAddress1][l*LANE_WIDTH +: LANE_WIDTH]) != dpar[bus.iDataReadAddress1][l]);
        perr_q[LANES+l] <= !byp2 && ((^dmem[bus.iDataReadAddress2][l*LANE_WIDTH +: LANE_WIDTH]) != dpar[bus.iDataReadAddress2][l]);
      end
    end
  end

  assign bus.oParityError = perr_q;
`endif

  // IMEM lives in the upper half of instruction space; ROM space is read-only.
  assign imem_wr   = bus.iInstructionWriteEnable && bus.iInstructionWriteAddress[INST_ADDR_WIDTH-1];
  assign imem_widx = bus.iInstructionWriteAddress[IMEM_ADDR_WIDTH-1:0];
  assign imem_ridx = bus.iInstructionReadAddress[IMEM_ADDR_WIDTH-1:0];

  // IMEM storage write.
  always_ff @(posedge Clock) begin
    if (imem_wr) imem[imem_widx] <= bus.iInstruction;
  end

  // Registered fetch: IMEM word (new word on same-index write), ROM word and MSB select.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sel_imem_q <= 1'b0;
      imem_rd_q  <= '0;
      rom_rd_q   <= '0;
    end else begin
      sel_imem_q <= bus.iInstructionReadAddress[INST_ADDR_WIDTH-1];
      imem_rd_q  <= (imem_wr && imem_widx == imem_ridx) ? bus.iInstruction : imem[imem_ridx];
      rom_rd_q   <= irom_word(imem_ridx);
    end
  end

  // Control register: load on strobe, otherwise hold.
  always_ff @(posedge Clock) begin
    if (Reset)                        cr_q <= '0;
    else if (bus.iControlWriteEnable) cr_q <= bus.iControlRegister;
  end

  // Address bits between the IMEM index and the space-select MSB are don't-care.
  assign unused_addr_bits = ^{bus.iInstructionReadAddress[INST_ADDR_WIDTH-2:IMEM_ADDR_WIDTH],
                              bus.iInstructionWriteAddress[INST_ADDR_WIDTH-2:IMEM_ADDR_WIDTH]};

  assign bus.oReady           = ready_q;
  assign bus.oDbgState        = state_q;
  assign bus.oData1           = rd1_q;
  assign bus.oData2           = rd2_q;
  assign bus.oInstruction     = sel_imem_q ? imem_rd_q : rom_rd_q;
  assign bus.oControlRegister = cr_q;
endmodule

// File: tb/tb_memory_unit_banked.sv
// Directed bench for memory_unit_banked with hand-computed expectations.
module tb_memory_unit_banked;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   n;

  memory_unit_banked_if bus ();

  memory_unit_banked dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until oReady rises, bounded.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!bus.oReady && cnt < 300) begin
      step();
      cnt++;
    end
  endtask

  task automatic dwrite(input logic [6:0] a, input logic [95:0] d, input logic [2:0] m);
    bus.iDataWriteEnable   = 1'b1;
    bus.iDataWriteAddress  = a;
    bus.iData              = d;
    bus.iDataWriteLaneMask = m;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.iDataWriteEnable         = 1'b0;
    bus.iDataWriteLaneMask       = '0;
    bus.iDataWriteAddress        = '0;
    bus.iData                    = '0;
    bus.iDataReadAddress1        = '0;
    bus.iDataReadAddress2        = '0;
    bus.iInstructionWriteEnable  = 1'b0;
    bus.iInstructionWriteAddress = '0;
    bus.iInstruction             = '0;
    bus.iInstructionReadAddress  = '0;
    bus.iControlWriteEnable      = 1'b0;
    bus.iControlRegister         = '0;
`ifdef MEM_PARITY_EN
    bus.iParityInject            = 1'b0;
`endif
    rst = 1'b1;
    step();
    check("rst_ready", bus.oReady, 0);
    check("rst_data1", bus.oData1, 0);
    check("rst_data2", bus.oData2, 0);
    check("rst_inst",  bus.oInstruction, 0);
    check("rst_cr",    bus.oControlRegister, 0);
    rst = 1'b0;

    // Write held throughout the clear must be dropped.
    dwrite(7'd7, {96{1'b1}}, 3'b111);
    bus.iDataReadAddress1 = 7'd7;
    wait_ready(n);
    check("clear_len", n, 128);
    bus.iDataWriteEnable = 1'b0;
    bus.iDataReadAddress1 = 7'd5;
    bus.iDataReadAddress2 = 7'd7;
    step();
    check("clear_rd5", bus.oData1, 0);
    check("clear_wr_dropped", bus.oData2, 0);

    // Masked writes
    dwrite(7'd10, 96'h11111111_22222222_33333333, 3'b111);
    step();
    dwrite(7'd10, 96'hAAAAAAAA_BBBBBBBB_CCCCCCCC, 3'b010);
    step();
    bus.iDataWriteEnable = 1'b0;
    bus.iDataReadAddress1 = 7'd10;
    bus.iDataReadAddress2 = 7'd10;
    step();
    check("mask_p1", bus.oData1, 96'h11111111_BBBBBBBB_33333333);
    check("mask_p2", bus.oData2, 96'h11111111_BBBBBBBB_33333333);

    // Enable with empty mask is a no-op, including through the bypass.
    dwrite(7'd10, {96{1'b1}}, 3'b000);
    step();
    check("mask0_byp", bus.oData1, 96'h11111111_BBBBBBBB_33333333);
    bus.iDataWriteEnable = 1'b0;
    step();
    check("mask0_mem", bus.oData1, 96'h11111111_BBBBBBBB_33333333);

    // Bypass on both ports, full then partial mask
    dwrite(7'd3, 96'hDEADBEEF_00000001_00000002, 3'b111);
    bus.iDataReadAddress1 = 7'd3;
    bus.iDataReadAddress2 = 7'd3;
    step();
    check("byp_p1", bus.oData1, 96'hDEADBEEF_00000001_00000002);
    check("byp_p2", bus.oData2, 96'hDEADBEEF_00000001_00000002);
    dwrite(7'd3, 96'h99999999_88888888_77777777, 3'b100);
    step();
    check("byp_part_p1", bus.oData1, 96'h99999999_00000001_00000002);
    check("byp_part_p2", bus.oData2, 96'h99999999_00000001_00000002);
    bus.iDataWriteEnable = 1'b0;
    bus.iDataReadAddress2 = 7'd10;
    step();
    check("byp_stored", bus.oData1, 96'h99999999_00000001_00000002);
    check("port2_indep", bus.oData2, 96'h11111111_BBBBBBBB_33333333);

    // Fetch mux
    bus.iInstructionWriteEnable  = 1'b1;
    bus.iInstructionWriteAddress = 16'h8004;
    bus.iInstruction             = 64'h0123456789ABCDEF;
    bus.iInstructionReadAddress  = 16'h8004;
    step();
    check("imem_rdw", bus.oInstruction, 64'h0123456789ABCDEF);
    bus.iInstructionWriteEnable = 1'b0;
    step();
    check("imem_rd", bus.oInstruction, 64'h0123456789ABCDEF);
    bus.iInstructionReadAddress = 16'h0004;
    step();
    check("irom_rd", bus.oInstruction, 64'hC0DE0004_5A5A0004);
    bus.iInstructionWriteEnable  = 1'b1;
    bus.iInstructionWriteAddress = 16'h0004;
    bus.iInstruction             = 64'hFFFFFFFF_FFFFFFFF;
    step();
    check("irom_wr_ignored", bus.oInstruction, 64'hC0DE0004_5A5A0004);
    bus.iInstructionWriteEnable = 1'b0;
    bus.iInstructionReadAddress = 16'h8404;
    step();
    check("imem_wrap", bus.oInstruction, 64'h0123456789ABCDEF);

    // Control register
    bus.iControlWriteEnable = 1'b1;
    bus.iControlRegister    = 16'h00A5;
    step();
    check("cr_load", bus.oControlRegister, 16'h00A5);
    bus.iControlWriteEnable = 1'b0;
    bus.iControlRegister    = 16'hFFFF;
    step();
    step();
    check("cr_hold", bus.oControlRegister, 16'h00A5);
`ifdef MEM_PARITY_EN
    check("parity_clean", bus.oParityError, 0);
`endif

    // Reset mid-clear restarts the counter
    rst = 1'b1;
    step();
    check("rst2_cr", bus.oControlRegister, 0);
    check("rst2_inst", bus.oInstruction, 0);
    rst = 1'b0;
    bus.iDataReadAddress1 = 7'd10;
    for (int i = 0; i < 50; i++) step();
    check("midclr_ready", bus.oReady, 0);
    check("midclr_data", bus.oData1, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready(n);
    check("reclear_len", n, 128);
    step();
    check("reclear_row10", bus.oData1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
